// File: rtl/vp_mac_pkg.sv
// vp_mac_pkg: shared types and helpers for the MAC stream transmitter.
package vp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREC,
    SCALE,
    DATA
  } tx_state_e;

  localparam int unsigned PREC_MAX = 8;
  localparam int unsigned ACT_W    = 8;
  localparam int unsigned WGT_W    = 8;

  // Data beat payload: activation in the upper byte, weight in the lower byte.
  function automatic logic [ACT_W+WGT_W-1:0] pack_data_beat(
    input logic [ACT_W-1:0] act,
    input logic [WGT_W-1:0] wgt
  );
    return {act, wgt};
  endfunction

endpackage

// File: rtl/vp_mac_stream_tx_if.sv
// vp_mac_stream_tx_if: AXI-Stream bundle for the MAC job packet output.
interface vp_mac_stream_tx_if #(
  parameter int DW    = 32,
  parameter int TID_W = 8
);
  logic             tvalid;
  logic             tready;
  logic [DW-1:0]    tdata;
  logic             tuser;
  logic             tlast;
  logic [TID_W-1:0] tid;

  modport master (output tvalid, tdata, tuser, tlast, tid, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, tid, output tready);
endinterface

// File: rtl/vp_axis_reg_slice.sv
// vp_axis_reg_slice: full-throughput 2-entry skid buffer; s_ready is registered.
// Only compiled when VP_MAC_TX_OUTREG_EN is defined.
`ifdef VP_MAC_TX_OUTREG_EN
module vp_axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  logic         sk_valid;
  logic [W-1:0] sk_data;

  assign s_ready = ~sk_valid;

  // Main register refills from the skid entry first; skid catches a beat while output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
    end else if (!m_valid || m_ready) begin
      if (sk_valid) begin
        m_valid  <= 1'b1;
        m_data   <= sk_data;
        sk_valid <= 1'b0;
      end else begin
        m_valid <= s_valid;
        if (s_valid) m_data <= s_data;
      end
    end else if (s_valid && !sk_valid) begin
      sk_valid <= 1'b1;
      sk_data  <= s_data;
    end
  end
endmodule
`endif

// File: rtl/vp_mac_stream_tx.sv
// vp_mac_stream_tx: builds one MAC job packet (precision, scale, NUM act/wgt beats).
// Macro VP_MAC_TX_OUTREG_EN: adds vp_axis_reg_slice on the output (+1 cycle latency,
// no combinational path from MO_AXIS.tready to ACT/WGT_TREADY).
module vp_mac_stream_tx
  import vp_mac_pkg::*;
#(
  parameter int AXIS_DW = 32,
  parameter int CNT_W   = 16,
  parameter int TID_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [3:0]            CMD_PRECISION,
  input  logic [31:0]           CMD_SCALE,
  input  logic [CNT_W-1:0]      CMD_NUM,
  input  logic                  ACT_TVALID,
  output logic                  ACT_TREADY,
  input  logic [ACT_W-1:0]      ACT_TDATA,
  input  logic                  WGT_TVALID,
  output logic                  WGT_TREADY,
  input  logic [WGT_W-1:0]      WGT_TDATA,
  vp_mac_stream_tx_if.master    MO_AXIS,
  output logic                  BUSY,
  output logic                  CMD_ERR
);
  tx_state_e          state, state_nxt;
  logic               out_of_reset;
  logic [31:0]        scale_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   cnt;

  logic               tx_valid, tx_ready, tx_user, tx_last;
  logic [AXIS_DW-1:0] tx_data;
  logic [TID_W-1:0]   tx_tid;

  logic cmd_fire, cmd_bad, slot_free, more, pair_fire, last_out;

  assign CMD_READY  = (state == IDLE) && out_of_reset;
  assign cmd_fire   = CMD_VALID && CMD_READY;
  assign cmd_bad    = (CMD_NUM == '0) || (CMD_PRECISION > 4'(PREC_MAX));
  assign slot_free  = !tx_valid || tx_ready;
  assign more       = (cnt != num_q);
  assign pair_fire  = (state == DATA) && ACT_TVALID && WGT_TVALID && slot_free && more;
  assign ACT_TREADY = pair_fire;
  assign WGT_TREADY = pair_fire;
  assign last_out   = tx_valid && tx_ready && tx_last;
  assign BUSY       = (state != IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: each header phase advances when its beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire && !cmd_bad) state_nxt = PREC;
      PREC:    if (tx_ready)             state_nxt = SCALE;
      SCALE:   if (tx_ready)             state_nxt = DATA;
      DATA:    if (last_out)             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, beat counter and output beat register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      out_of_reset <= 1'b0;
      CMD_ERR      <= 1'b0;
      scale_q      <= '0;
      num_q        <= '0;
      cnt          <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      tx_user      <= 1'b0;
      tx_last      <= 1'b0;
      tx_tid       <= '0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_bad) begin
              CMD_ERR <= 1'b1;
            end else begin
              scale_q  <= CMD_SCALE;
              num_q    <= CMD_NUM;
              cnt      <= '0;
              tx_valid <= 1'b1;
              tx_data  <= AXIS_DW'(CMD_PRECISION);
              tx_user  <= 1'b1;
              tx_last  <= 1'b0;
              tx_tid   <= '0;
            end
          end
        end
        PREC: begin
          if (tx_ready) begin
            tx_data <= AXIS_DW'(scale_q);
            tx_user <= 1'b0;
          end
        end
        SCALE: begin
          if (tx_ready) tx_valid <= 1'b0;
        end
        DATA: begin
          if (pair_fire) begin
            tx_valid <= 1'b1;
            tx_data  <= AXIS_DW'(pack_data_beat(ACT_TDATA, WGT_TDATA));
            tx_tid   <= cnt[TID_W-1:0];
            tx_last  <= (cnt == num_q - CNT_W'(1));
            cnt      <= cnt + CNT_W'(1);
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VP_MAC_TX_OUTREG_EN
  vp_axis_reg_slice #(
    .W(AXIS_DW + TID_W + 2)
  ) u_out_slice (
    .clk     (CLK),
    .rst_n   (RESETN),
    .s_valid (tx_valid),
    .s_ready (tx_ready),
    .s_data  ({tx_data, tx_user, tx_last, tx_tid}),
    .m_valid (MO_AXIS.tvalid),
    .m_ready (MO_AXIS.tready),
    .m_data  ({MO_AXIS.tdata, MO_AXIS.tuser, MO_AXIS.tlast, MO_AXIS.tid})
  );
`else
  assign MO_AXIS.tvalid = tx_valid;
  assign MO_AXIS.tdata  = tx_data;
  assign MO_AXIS.tuser  = tx_user;
  assign MO_AXIS.tlast  = tx_last;
  assign MO_AXIS.tid    = tx_tid;
  assign tx_ready       = MO_AXIS.tready;
`endif

endmodule

// File: tb/tb_vp_mac_stream_tx.sv
// tb_vp_mac_stream_tx: randomized self-checking bench for vp_mac_stream_tx.
module tb_vp_mac_stream_tx;
  localparam int AXIS_DW = 32;
  localparam int CNT_W   = 16;
  localparam int TID_W   = 8;

  logic             CLK = 1'b0;
  logic             RESETN = 1'b0;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [3:0]       CMD_PRECISION = '0;
  logic [31:0]      CMD_SCALE = '0;
  logic [CNT_W-1:0] CMD_NUM = '0;
  logic             ACT_TVALID, ACT_TREADY;
  logic [7:0]       ACT_TDATA;
  logic             WGT_TVALID, WGT_TREADY;
  logic [7:0]       WGT_TDATA;
  logic             BUSY, CMD_ERR;

  vp_mac_stream_tx_if #(.DW(AXIS_DW), .TID_W(TID_W)) mo_if ();

  vp_mac_stream_tx #(
    .AXIS_DW(AXIS_DW),
    .CNT_W  (CNT_W),
    .TID_W  (TID_W)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_PRECISION(CMD_PRECISION),
    .CMD_SCALE    (CMD_SCALE),
    .CMD_NUM      (CMD_NUM),
    .ACT_TVALID   (ACT_TVALID),
    .ACT_TREADY   (ACT_TREADY),
    .ACT_TDATA    (ACT_TDATA),
    .WGT_TVALID   (WGT_TVALID),
    .WGT_TREADY   (WGT_TREADY),
    .WGT_TDATA    (WGT_TDATA),
    .MO_AXIS      (mo_if),
    .BUSY         (BUSY),
    .CMD_ERR      (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  act_q[$];
  logic [7:0]  wgt_q[$];
  logic [41:0] obs_q[$];
  logic [41:0] exp_q[$];
  bit          act_en = 1'b1;
  bit          wgt_en = 1'b1;
  int unsigned stall_pct = 0;
  int          act_rdy_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [41:0] mk_beat(input logic [7:0] tid, input logic last,
                                          input logic user, input logic [31:0] data);
    return {tid, last, user, data};
  endfunction

  // Output back-pressure.
  initial begin
    mo_if.tready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      mo_if.tready = ($urandom_range(99) >= stall_pct);
    end
  end

  // Activation / weight byte sources; each byte held until taken.
  initial begin
    bit take_a, take_w;
    ACT_TVALID = 1'b0; ACT_TDATA = '0;
    WGT_TVALID = 1'b0; WGT_TDATA = '0;
    forever begin
      @(negedge CLK);
      take_a = RESETN && ACT_TVALID && ACT_TREADY;
      take_w = RESETN && WGT_TVALID && WGT_TREADY;
      if (RESETN && (ACT_TREADY || WGT_TREADY))
        check_eq("pair_ready", ACT_TREADY, WGT_TREADY);
      if (ACT_TREADY) act_rdy_seen++;
      @(posedge CLK);
      #1;
      if (!RESETN) begin
        ACT_TVALID = 1'b0; WGT_TVALID = 1'b0;
        act_q.delete(); wgt_q.delete();
      end else begin
        if (take_a) begin void'(act_q.pop_front()); ACT_TVALID = 1'b0; end
        if (take_w) begin void'(wgt_q.pop_front()); WGT_TVALID = 1'b0; end
        if (!ACT_TVALID && act_en && act_q.size() != 0 && $urandom_range(99) < 75) begin
          ACT_TVALID = 1'b1; ACT_TDATA = act_q[0];
        end
        if (!WGT_TVALID && wgt_en && wgt_q.size() != 0 && $urandom_range(99) < 75) begin
          WGT_TVALID = 1'b1; WGT_TDATA = wgt_q[0];
        end
      end
    end
  end

  // Output monitor: records accepted beats and checks hold-while-stalled.
  initial begin
    bit          hold_prev = 1'b0;
    logic [41:0] prev_beat = '0;
    logic [41:0] cur;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        hold_prev = 1'b0;
        continue;
      end
      cur = mk_beat(mo_if.tid, mo_if.tlast, mo_if.tuser, mo_if.tdata);
      if (hold_prev) begin
        check_eq("hold_valid", mo_if.tvalid, 1);
        if (mo_if.tvalid) check_eq("hold_beat", cur, prev_beat);
      end
      hold_prev = mo_if.tvalid && !mo_if.tready;
      prev_beat = cur;
      if (mo_if.tvalid && mo_if.tready) obs_q.push_back(cur);
    end
  end

  task automatic prep_job(input logic [3:0] prec, input logic [31:0] scale, input int num,
                          input bit fixed, input logic [7:0] a0, input logic [7:0] w0);
    logic [7:0] a, w;
    obs_q.delete(); exp_q.delete(); act_q.delete(); wgt_q.delete();
    exp_q.push_back(mk_beat(8'h00, 1'b0, 1'b1, {28'h0, prec}));
    exp_q.push_back(mk_beat(8'h00, 1'b0, 1'b0, scale));
    for (int k = 0; k < num; k++) begin
      a = (fixed && k == 0) ? a0 : 8'($urandom);
      w = (fixed && k == 0) ? w0 : 8'($urandom);
      act_q.push_back(a);
      wgt_q.push_back(w);
      exp_q.push_back(mk_beat(8'(k), (k == num - 1), 1'b0, {16'h0, a, w}));
    end
  endtask

  task automatic send_cmd(input logic [3:0] prec, input logic [31:0] scale, input int num);
    bit ok = 1'b0;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_PRECISION = prec; CMD_SCALE = scale; CMD_NUM = CNT_W'(num);
    for (int i = 0; i < 50; i++) begin
      if (CMD_READY) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    if (!ok) check_eq("cmd_ready_wait", CMD_READY, 1);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic check_latency();
`ifdef VP_MAC_TX_OUTREG_EN
    @(posedge CLK);
    #1;
`endif
    check_eq("lat_tvalid", mo_if.tvalid, 1);
    check_eq("lat_tuser", mo_if.tuser, 1);
  endtask

  task automatic finish_job(input int num);
    int cyc = 0;
    while (obs_q.size() < num + 2 && cyc < num * 30 + 200) begin
      @(negedge CLK);
      cyc++;
    end
    check_eq("beat_count", obs_q.size(), num + 2);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check_eq($sformatf("beat%0d", i), obs_q[i], exp_q[i]);
    @(negedge CLK);
    check_eq("idle_busy", BUSY, 0);
    check_eq("idle_cmd_ready", CMD_READY, 1);
    check_eq("bytes_left", act_q.size() + wgt_q.size(), 0);
  endtask

  task automatic run_job(input logic [3:0] prec, input logic [31:0] scale, input int num,
                         input int unsigned stall, input bit fixed,
                         input logic [7:0] a0, input logic [7:0] w0);
    stall_pct = stall;
    prep_job(prec, scale, num, fixed, a0, w0);
    send_cmd(prec, scale, num);
    check_latency();
    finish_job(num);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state.
    #3;
    check_eq("rst_tvalid", mo_if.tvalid, 0);
    check_eq("rst_cmd_ready", CMD_READY, 0);
    check_eq("rst_act_ready", ACT_TREADY, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_err", CMD_ERR, 0);
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_cmd_ready", CMD_READY, 1);

    // Directed packet.
    run_job(4'd3, 32'h0000009C, 10, 0, 1'b0, 8'h00, 8'h00);

    // Fixed byte pair, then the same pair under stalls.
    run_job(4'd5, 32'h00018000, 1, 0, 1'b1, 8'hA5, 8'h3C);
    if (obs_q.size() > 2) check_eq("a5_3c_tdata", obs_q[2][31:0], 32'h0000A53C);
    run_job(4'd8, 32'hDEADBEEF, 12, 60, 1'b1, 8'hA5, 8'h3C);

    // Weight stream idle while activation offered.
    stall_pct = 0;
    prep_job(4'd2, 32'h00010000, 4, 1'b0, 8'h00, 8'h00);
    wgt_en = 1'b0;
    send_cmd(4'd2, 32'h00010000, 4);
    check_latency();
    cyc = 0;
    while (obs_q.size() < 2 && cyc < 50) begin @(negedge CLK); cyc++; end
    act_rdy_seen = 0;
    repeat (20) @(negedge CLK);
    check_eq("gap_act_ready", act_rdy_seen, 0);
    check_eq("gap_no_beat", obs_q.size(), 2);
    check_eq("gap_act_kept", act_q.size(), 4);
    wgt_en = 1'b1;
    finish_job(4);

    // Error commands.
    obs_q.delete();
    check_eq("err_before", CMD_ERR, 0);
    send_cmd(4'd3, 32'h1, 0);
    check_eq("err_num0", CMD_ERR, 1);
    check_eq("err_num0_tvalid", mo_if.tvalid, 0);
    @(negedge CLK);
    check_eq("err_num0_ready", CMD_READY, 1);
    send_cmd(4'd9, 32'h1, 5);
    check_eq("err_prec9", CMD_ERR, 1);
    check_eq("err_prec9_busy", BUSY, 0);
    @(negedge CLK);
    check_eq("err_prec9_ready", CMD_READY, 1);
    repeat (5) @(negedge CLK);
    check_eq("err_no_beats", obs_q.size(), 0);

    // Reset in the middle of the data phase.
    stall_pct = 0;
    prep_job(4'd4, 32'h00020000, 10, 1'b0, 8'h00, 8'h00);
    send_cmd(4'd4, 32'h00020000, 10);
    cyc = 0;
    while (obs_q.size() < 6 && cyc < 200) begin @(negedge CLK); cyc++; end
    #2;
    RESETN = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", mo_if.tvalid, 0);
    check_eq("mid_rst_tdata", mo_if.tdata, 0);
    check_eq("mid_rst_tlast", mo_if.tlast, 0);
    check_eq("mid_rst_tid", mo_if.tid, 0);
    check_eq("mid_rst_act_ready", ACT_TREADY, 0);
    check_eq("mid_rst_busy", BUSY, 0);
    check_eq("mid_rst_cmd_ready", CMD_READY, 0);
    check_eq("mid_rst_err", CMD_ERR, 0);
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);
    run_job(4'd6, 32'h00004000, 7, 30, 1'b0, 8'h00, 8'h00);

    // TID wrap across a long packet.
    run_job(4'd1, 32'h12345678, 300, 20, 1'b0, 8'h00, 8'h00);
    if (obs_q.size() > 259) begin
      check_eq("tid_255", obs_q[257][41:34], 8'd255);
      check_eq("tid_wrap", obs_q[258][41:34], 8'd0);
      check_eq("tlast_wrap", obs_q[258][33], 0);
    end

    // Random jobs.
    for (int j = 0; j < 8; j++)
      run_job(4'($urandom_range(8)), $urandom, int'($urandom_range(40, 1)),
              $urandom_range(70), 1'b0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
